// File: rtl/passwd_bank.sv
// ---------------------------------------------------------------------------
// passwd_bank
//
// Keypad password bank. Digits are shifted into an entry buffer. A submit
// either commits the buffer as the new stored password (set mode) or compares
// it against the stored password (check mode). Too many consecutive failed
// checks put the block into a timed lockout. During lockout every strobe is
// ignored.
//
// Parameters
//   DIGITS      password length in digits (2..16)
//   DW          bits per digit
//   BAD_CODE    illegal digit code; it is stored as zero
//   MAX_FAIL    consecutive failed checks that trigger lockout (1..15)
//   LOCK_CYCLES lockout duration in clk cycles (>= 1)
//
// Ports
//   clk        clock, rising edge
//   clr        asynchronous active-low reset
//   key_valid  strobe: key_code holds a digit
//   key_code   digit value
//   key_del    strobe: remove the most recently entered digit
//   key_ent    strobe: submit the entry buffer
//   mode_set   level, sampled only with key_ent: 1 = set, 0 = check
//   entry_cnt  number of digits currently held in the entry buffer
//   stored     stored password; the first-entered digit is in the top DW bits
//   match      pulse: check succeeded
//   fail       pulse: check failed, or a set attempt was rejected
//   set_done   pulse: new password committed
//   locked     level: lockout in progress
// ---------------------------------------------------------------------------
module passwd_bank #(
    parameter int unsigned   DIGITS      = 6,
    parameter int unsigned   DW          = 4,
    parameter logic [DW-1:0] BAD_CODE    = DW'(4'hE),
    parameter int unsigned   MAX_FAIL    = 3,
    parameter int unsigned   LOCK_CYCLES = 1000
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         key_valid,
    input  logic [DW-1:0]                key_code,
    input  logic                         key_del,
    input  logic                         key_ent,
    input  logic                         mode_set,
    output logic [$clog2(DIGITS+1)-1:0]  entry_cnt,
    output logic [DIGITS*DW-1:0]         stored,
    output logic                         match,
    output logic                         fail,
    output logic                         set_done,
    output logic                         locked
);

    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam int unsigned BW = DIGITS * DW;
    localparam int unsigned TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    localparam logic [CW-1:0] FULL       = CW'(DIGITS);
    localparam logic [3:0]    FAIL_LIM   = 4'(MAX_FAIL);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(LOCK_CYCLES - 1);

    typedef enum logic {
        ST_OPEN = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t          state;
    logic [BW-1:0]   buffer;
    logic [3:0]      fail_cnt;
    logic [TW-1:0]   timer;

    logic [DW-1:0]   digit;
    logic            full;
    logic            empty;
    logic [3:0]      fail_next;

    always_comb begin
        digit     = (key_code == BAD_CODE) ? '0 : key_code;
        full      = (entry_cnt == FULL);
        empty     = (entry_cnt == '0);
        fail_next = fail_cnt + 4'd1;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= ST_OPEN;
            stored    <= '0;
            buffer    <= '0;
            entry_cnt <= '0;
            fail_cnt  <= '0;
            timer     <= '0;
            match     <= 1'b0;
            fail      <= 1'b0;
            set_done  <= 1'b0;
            locked    <= 1'b0;
        end else begin
            match    <= 1'b0;
            fail     <= 1'b0;
            set_done <= 1'b0;

            case (state)
                ST_OPEN: begin
                    if (key_ent) begin
                        buffer    <= '0;
                        entry_cnt <= '0;
                        if (mode_set) begin
                            // A rejected set attempt leaves the fail counter alone.
                            if (full) begin
                                stored   <= buffer;
                                set_done <= 1'b1;
                            end else begin
                                fail <= 1'b1;
                            end
                        end else if (full && (buffer == stored)) begin
                            match    <= 1'b1;
                            fail_cnt <= '0;
                        end else begin
                            fail     <= 1'b1;
                            fail_cnt <= fail_next;
                            // locked rises together with the fail pulse that
                            // reaches the limit.
                            if (fail_next == FAIL_LIM) begin
                                state  <= ST_LOCK;
                                locked <= 1'b1;
                                timer  <= TIMER_LOAD;
                            end
                        end
                    end else if (key_del) begin
                        // A delete on an empty buffer still swallows key_valid.
                        if (!empty) begin
                            buffer    <= {{DW{1'b0}}, buffer[BW-1:DW]};
                            entry_cnt <= entry_cnt - 1'b1;
                        end
                    end else if (key_valid && !full) begin
                        buffer    <= {buffer[BW-DW-1:0], digit};
                        entry_cnt <= entry_cnt + 1'b1;
                    end
                end

                ST_LOCK: begin
                    buffer    <= '0;
                    entry_cnt <= '0;
                    // The timer loads LOCK_CYCLES-1 and the exit happens on the
                    // edge that sees zero, giving exactly LOCK_CYCLES locked cycles.
                    if (timer == '0) begin
                        state    <= ST_OPEN;
                        fail_cnt <= '0;
                        locked   <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                default: begin
                    state <= ST_OPEN;
                end
            endcase
        end
    end

endmodule
